run_checker: RTL and testbench
==============================

# run_checker

Synthesizable end-of-run checker for the single-cycle MIPS test system. It watches the instruction bus to detect program completion: a run of consecutive NOPs, or a watchdog cycle limit. It then takes over the data memory address port and reads back result words one per cycle, comparing each against an external reference ROM. Per-instruction-class pass counts and an overall pass flag are produced, so the bring-up check can run on hardware without a simulator.

## Interface
Parameters:
- TIMEOUT, 9, consecutive zero instructions that mark end of program
- WATCHDOG, 500, maximum RUN cycles before a forced end of run
- NUM_WORDS, 22, result words scanned, at word indices 0..NUM_WORDS-1

Ports:
- clk  in  1  system clock, rising edge active
- rst_n  in  1  reset; one clock, asynchronous, active-low
- inst  in  32  instruction currently fetched by the core
- data_out  in  32  data memory read data, combinational from scan_addr
- ref_data  in  32  reference word, combinational from ref_addr
- scan_active  out  1  high in SCAN; integrator muxes scan_addr onto data_addr and forces data_wr=0
- scan_addr  out  32  byte address idx*4 (big-endian word)
- ref_addr  out  7  word index idx
- ldst_cnt, add_cnt, beq_cnt, sub_cnt, slt_cnt, bne_cnt  out  3 each  per-class match counts
- done  out  1  scan complete
- timeout  out  1  end of run caused by the watchdog
- pass  out  1  all classes full

## Operation
- FSM states: RUN → SCAN → DONE. DONE is terminal until reset.
- RUN, at each rising edge:
  - nop_cnt = (inst==0) ? nop_cnt+1 : 0
  - cyc_cnt = cyc_cnt+1
  - Go to SCAN, with idx=0, when next nop_cnt==TIMEOUT or next cyc_cnt==WATCHDOG.
  - timeout <= 1 only if the watchdog condition holds and the NOP condition does not hold on the same edge. The NOP condition wins a tie.
- Counter widths: nop_cnt is clog2(TIMEOUT+1) bits; cyc_cnt is clog2(WATCHDOG+1) bits. Both stop counting outside RUN.
- SCAN, at each rising edge:
  - Sample match = (data_out==ref_data) for the current idx.
  - On a match, increment the class counter for that idx:
    - 3, 4, 6 → ldst
    - 7–10 → add
    - 11–14 → beq
    - 15–18 → sub
    - 19, 20 → slt
    - 21 → bne
  - Indices 0, 1, 2 and 5 are never counted.
  - idx++. When idx==NUM_WORDS-1, go to DONE instead.
- DONE:
  - done=1; all counters, timeout and scan_addr hold.
  - pass=1 iff counts are ldst=3, add=4, beq=4, sub=4, slt=2, bne=1, independent of timeout.
- Outputs are registered except scan_addr and ref_addr, which are decoded from the idx register. There is no combinational path from inst to any output.

## Timing
- Reset (asynchronous, any state): state=RUN, nop_cnt=cyc_cnt=idx=0, all counts 0, scan_active=done=timeout=pass=0, scan_addr=0, ref_addr=0.
- Reset asserted mid-SCAN aborts the scan immediately; there is no partial result.
- scan_active rises on the edge that leaves RUN. scan_addr=0 is valid during the first SCAN cycle.
- Scan latency: exactly NUM_WORDS cycles in SCAN. done and pass rise on the edge after the last compare.
- Memory and ROM reads are combinational, so each word is compared in the same cycle its address is presented.
- A nonzero inst in the same cycle that nop_cnt would reach TIMEOUT clears the count; no transition.

## Test plan
- inst nonzero for 3 edges, then 0: scan_active=1 after edge 12; done=1 exactly 22 edges later; timeout=0.
- Memory equals reference for all 22 words: counts ldst=3, add=4, beq=4, sub=4, slt=2, bne=1; pass=1.
- Mismatch at word 5 and word 12: word 5 ignored; beq=3, all other classes full; pass=0.
- inst never zero: scan starts after edge 500; timeout=1; with memory matching, pass=1.
- 8 zeros, 1 nonzero, then 9 zeros: no SCAN until the second run completes, at edge 18 from the first zero.
- rst_n pulsed low with idx=10 in SCAN: all outputs 0 asynchronously, state RUN. A following clean run completes normally.

Source files
------------

// File: rtl/run_checker_if.sv
// Scan bus between the end-of-run checker and the test system: instruction
// watch input plus the data-memory / reference-ROM readback path.
interface run_checker_if;
  logic [31:0] inst;
  logic [31:0] data_out;
  logic [31:0] ref_data;
  logic        scan_active;
  logic [31:0] scan_addr;
  logic [6:0]  ref_addr;

  modport master (
    input  inst, data_out, ref_data,
    output scan_active, scan_addr, ref_addr
  );

  modport slave (
    output inst, data_out, ref_data,
    input  scan_active, scan_addr, ref_addr
  );
endinterface

// File: rtl/run_checker.sv
// End-of-run checker: detects program completion (NOP run or watchdog), then
// scans result words against a reference ROM and tallies per-class matches.
module run_checker #(
  parameter int TIMEOUT   = 9,
  parameter int WATCHDOG  = 500,
  parameter int NUM_WORDS = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  run_checker_if.master        bus,
  output logic [2:0]           ldst_cnt,
  output logic [2:0]           add_cnt,
  output logic [2:0]           beq_cnt,
  output logic [2:0]           sub_cnt,
  output logic [2:0]           slt_cnt,
  output logic [2:0]           bne_cnt,
  output logic                 done,
  output logic                 timeout,
  output logic                 pass
);

  localparam int NOP_W = $clog2(TIMEOUT + 1);
  localparam int CYC_W = $clog2(WATCHDOG + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NOP_W-1:0] nop_q, nop_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [6:0]       idx_q, idx_d;
  logic [2:0]       ldst_d, add_d, beq_d, sub_d, slt_d, bne_d;
  logic             scan_q, scan_d;
  logic             done_d, timeout_d, pass_d;
  logic             nop_hit, wd_hit, match;

  assign bus.scan_active = scan_q;
  assign bus.scan_addr   = {23'b0, idx_q, 2'b00};
  assign bus.ref_addr    = idx_q;

  always_comb begin
    state_d   = state_q;
    nop_d     = nop_q;
    cyc_d     = cyc_q;
    idx_d     = idx_q;
    ldst_d    = ldst_cnt;
    add_d     = add_cnt;
    beq_d     = beq_cnt;
    sub_d     = sub_cnt;
    slt_d     = slt_cnt;
    bne_d     = bne_cnt;
    scan_d    = scan_q;
    done_d    = done;
    timeout_d = timeout;
    pass_d    = pass;
    nop_hit   = 1'b0;
    wd_hit    = 1'b0;
    match     = 1'b0;

    case (state_q)
      S_RUN: begin
        nop_d   = (bus.inst == '0) ? nop_q + NOP_W'(1) : '0;
        cyc_d   = cyc_q + CYC_W'(1);
        nop_hit = (nop_d == NOP_W'(TIMEOUT));
        wd_hit  = (cyc_d == CYC_W'(WATCHDOG));
        if (nop_hit || wd_hit) begin
          state_d   = S_SCAN;
          idx_d     = '0;
          scan_d    = 1'b1;
          // NOP completion wins a same-edge tie with the watchdog
          timeout_d = wd_hit && !nop_hit;
        end
      end

      S_SCAN: begin
        match = (bus.data_out == bus.ref_data);
        if (match) begin
          case (idx_q)
            7'd3, 7'd4, 7'd6:           ldst_d = ldst_cnt + 3'd1;
            7'd7, 7'd8, 7'd9, 7'd10:    add_d  = add_cnt  + 3'd1;
            7'd11, 7'd12, 7'd13, 7'd14: beq_d  = beq_cnt  + 3'd1;
            7'd15, 7'd16, 7'd17, 7'd18: sub_d  = sub_cnt  + 3'd1;
            7'd19, 7'd20:               slt_d  = slt_cnt  + 3'd1;
            7'd21:                      bne_d  = bne_cnt  + 3'd1;
            default: ;
          endcase
        end
        if (idx_q == 7'(NUM_WORDS - 1)) begin
          state_d = S_DONE;
          scan_d  = 1'b0;
          done_d  = 1'b1;
          // Judged on the post-increment counts so pass rises with done
          pass_d  = (ldst_d == 3'd3) && (add_d == 3'd4) && (beq_d == 3'd4) &&
                    (sub_d == 3'd4) && (slt_d == 3'd2) && (bne_d == 3'd1);
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end

      S_DONE: ;

      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      nop_q    <= '0;
      cyc_q    <= '0;
      idx_q    <= '0;
      ldst_cnt <= '0;
      add_cnt  <= '0;
      beq_cnt  <= '0;
      sub_cnt  <= '0;
      slt_cnt  <= '0;
      bne_cnt  <= '0;
      scan_q   <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state_q  <= state_d;
      nop_q    <= nop_d;
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      ldst_cnt <= ldst_d;
      add_cnt  <= add_d;
      beq_cnt  <= beq_d;
      sub_cnt  <= sub_d;
      slt_cnt  <= slt_d;
      bne_cnt  <= bne_d;
      scan_q   <= scan_d;
      done     <= done_d;
      timeout  <= timeout_d;
      pass     <= pass_d;
    end
  end

endmodule

// File: tb/tb_run_checker.sv
// Directed bench for run_checker: NOP/watchdog completion, scan results,
// pass/fail decoding, watchdog tie-break and asynchronous reset mid-scan.
module tb_run_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  run_checker_if bus ();
  run_checker_if bus2 ();

  logic [2:0] ldst_cnt, add_cnt, beq_cnt, sub_cnt, slt_cnt, bne_cnt;
  logic       done, timeout, pass;
  logic [2:0] t_ldst, t_add, t_beq, t_sub, t_slt, t_bne;
  logic       t_done, t_timeout, t_pass;

  logic [31:0] mem [0:127];
  logic [31:0] rom [0:127];

  int n_tests = 0;
  int n_fail  = 0;

  run_checker #(.TIMEOUT(9), .WATCHDOG(500), .NUM_WORDS(22)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master),
    .ldst_cnt(ldst_cnt), .add_cnt(add_cnt), .beq_cnt(beq_cnt),
    .sub_cnt(sub_cnt), .slt_cnt(slt_cnt), .bne_cnt(bne_cnt),
    .done(done), .timeout(timeout), .pass(pass)
  );

  // Short watchdog so that NOP completion and watchdog expiry coincide
  run_checker #(.TIMEOUT(9), .WATCHDOG(12), .NUM_WORDS(22)) dut_tie (
    .clk(clk), .rst_n(rst_n), .bus(bus2.master),
    .ldst_cnt(t_ldst), .add_cnt(t_add), .beq_cnt(t_beq),
    .sub_cnt(t_sub), .slt_cnt(t_slt), .bne_cnt(t_bne),
    .done(t_done), .timeout(t_timeout), .pass(t_pass)
  );

  always_comb begin
    bus.data_out  = mem[bus.scan_addr[8:2]];
    bus.ref_data  = rom[bus.ref_addr];
    bus2.inst     = bus.inst;
    bus2.data_out = mem[bus2.scan_addr[8:2]];
    bus2.ref_data = rom[bus2.ref_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.inst = 32'h2008_0001;
    #2;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 128; i++) mem[i] = rom[i];
  endtask

  task automatic chk_result(input string tag, input logic [2:0] exp_beq,
                            input logic exp_pass, input logic exp_to);
    chk({tag, ".done"},    {31'b0, done},    32'd1);
    chk({tag, ".ldst"},    {29'b0, ldst_cnt}, 32'd3);
    chk({tag, ".add"},     {29'b0, add_cnt},  32'd4);
    chk({tag, ".beq"},     {29'b0, beq_cnt},  {29'b0, exp_beq});
    chk({tag, ".sub"},     {29'b0, sub_cnt},  32'd4);
    chk({tag, ".slt"},     {29'b0, slt_cnt},  32'd2);
    chk({tag, ".bne"},     {29'b0, bne_cnt},  32'd1);
    chk({tag, ".pass"},    {31'b0, pass},    {31'b0, exp_pass});
    chk({tag, ".timeout"}, {31'b0, timeout}, {31'b0, exp_to});
    chk({tag, ".active"},  {31'b0, bus.scan_active}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    load_mem();
    bus.inst = 32'h2008_0001;

    // Reset values
    rst_n = 1'b0;
    #2;
    chk("rst.active", {31'b0, bus.scan_active}, 32'd0);
    chk("rst.done",   {31'b0, done}, 32'd0);
    chk("rst.addr",   bus.scan_addr, 32'd0);
    chk("rst.ref",    {25'b0, bus.ref_addr}, 32'd0);

    // Test 1: 3 nonzero, then NOPs; SCAN after edge 12, DONE after edge 34
    do_reset();
    tick(3);
    bus.inst = 32'h0;
    tick(8);
    chk("t1.e11.active", {31'b0, bus.scan_active}, 32'd0);
    tick(1);
    chk("t1.e12.active", {31'b0, bus.scan_active}, 32'd1);
    chk("t1.e12.addr",   bus.scan_addr, 32'd0);
    chk("t1.e12.to",     {31'b0, timeout}, 32'd0);
    chk("tie.e12.active", {31'b0, bus2.scan_active}, 32'd1);
    chk("tie.e12.to",     {31'b0, t_timeout}, 32'd0);
    tick(1);
    chk("t1.e13.addr", bus.scan_addr, 32'd4);
    chk("t1.e13.ref",  {25'b0, bus.ref_addr}, 32'd1);
    tick(20);
    chk("t1.e33.done", {31'b0, done}, 32'd0);
    tick(1);
    chk_result("t1", 3'd4, 1'b1, 1'b0);
    chk("t1.addr", bus.scan_addr, 32'd84);
    bus.inst = 32'h2008_0001;
    tick(5);
    chk("t1.hold.done", {31'b0, done}, 32'd1);
    chk("t1.hold.addr", bus.scan_addr, 32'd84);
    chk("t1.hold.ldst", {29'b0, ldst_cnt}, 32'd3);

    // Test 2: mismatches at word 5 (ignored) and word 12 (beq)
    mem[5]  = rom[5] ^ 32'h1;
    mem[12] = rom[12] ^ 32'h8000_0000;
    do_reset();
    bus.inst = 32'h0;
    tick(9);
    chk("t2.e9.active", {31'b0, bus.scan_active}, 32'd1);
    tick(22);
    chk_result("t2", 3'd3, 1'b0, 1'b0);
    load_mem();

    // Test 3: inst never zero; watchdog at edge 500
    do_reset();
    tick(12);
    chk("tie.wd.active", {31'b0, bus2.scan_active}, 32'd1);
    chk("tie.wd.to",     {31'b0, t_timeout}, 32'd1);
    tick(487);
    chk("t3.e499.active", {31'b0, bus.scan_active}, 32'd0);
    tick(1);
    chk("t3.e500.active", {31'b0, bus.scan_active}, 32'd1);
    chk("t3.e500.to",     {31'b0, timeout}, 32'd1);
    tick(22);
    chk_result("t3", 3'd4, 1'b1, 1'b1);

    // Test 4: 8 zeros, 1 nonzero, 9 zeros; SCAN at edge 18
    do_reset();
    bus.inst = 32'h0;
    tick(8);
    bus.inst = 32'h2008_0001;
    tick(1);
    bus.inst = 32'h0;
    tick(8);
    chk("t4.e17.active", {31'b0, bus.scan_active}, 32'd0);
    tick(1);
    chk("t4.e18.active", {31'b0, bus.scan_active}, 32'd1);
    chk("t4.e18.to",     {31'b0, timeout}, 32'd0);

    // Test 5: asynchronous reset with idx=10 in SCAN, then a clean run
    do_reset();
    bus.inst = 32'h0;
    tick(19);
    chk("t5.idx10.addr", bus.scan_addr, 32'd40);
    chk("t5.idx10.ldst", {29'b0, ldst_cnt}, 32'd3);
    chk("t5.idx10.add",  {29'b0, add_cnt}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.rst.active", {31'b0, bus.scan_active}, 32'd0);
    chk("t5.rst.addr",   bus.scan_addr, 32'd0);
    chk("t5.rst.ref",    {25'b0, bus.ref_addr}, 32'd0);
    chk("t5.rst.cnts",   {14'b0, ldst_cnt, add_cnt, beq_cnt, sub_cnt, slt_cnt, bne_cnt}, 32'd0);
    chk("t5.rst.flags",  {29'b0, done, timeout, pass}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(8);
    chk("t5.e8.active", {31'b0, bus.scan_active}, 32'd0);
    tick(1);
    chk("t5.e9.active", {31'b0, bus.scan_active}, 32'd1);
    tick(22);
    chk_result("t5", 3'd4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
